// File: rtl/wash_timer_if.sv
// Timer handshake between the wash sequencer (master) and its phase timer (slave).
// The master loads freq/period, pulses clr and holds enable; the timer answers with done.
interface wash_timer_if;
    logic       timer_clr;
    logic       timer_enable;
    logic [3:0] timer_freq;
    logic [3:0] timer_period;
    logic       timer_done;

    modport master (
        output timer_clr,
        output timer_enable,
        output timer_freq,
        output timer_period,
        input  timer_done
    );

    modport slave (
        input  timer_clr,
        input  timer_enable,
        input  timer_freq,
        input  timer_period,
        output timer_done
    );
endinterface

// File: rtl/wash_cycle_ctrl.sv
// Washing-machine phase sequencer FILL -> WASH -> RINSE -> SPIN driving a timer and actuators.
// Every output is registered; next-state logic computes the registered outputs from the next state.
module wash_cycle_ctrl #(
    parameter logic [3:0] CLK_FREQ     = 4'd5,
    parameter logic [3:0] FILL_PERIOD  = 4'd2,
    parameter logic [3:0] WASH_PERIOD  = 4'd5,
    parameter logic [3:0] RINSE_PERIOD = 4'd3,
    parameter logic [3:0] SPIN_PERIOD  = 4'd4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              pause_i,
    input  logic              abort_i,
    input  logic              door_closed_i,
    wash_timer_if.master      tmr,
    output logic [2:0]        state_o,
    output logic              water_valve_o,
    output logic              motor_on_o,
    output logic              drain_o,
    output logic              cycle_done_o
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} fsm_t;

    localparam logic [2:0] PH_IDLE = 3'd0;
    localparam logic [2:0] PH_DONE = 3'd5;

    fsm_t       fsm_q, fsm_d;
    logic [2:0] phase_q, phase_d;
    logic       held_q, held_d;
    logic       clr_q, clr_d;
    logic       en_q, en_d;
    logic [3:0] freq_q;
    logic [3:0] period_q, period_d;
    logic [2:0] state_q, state_d;
    logic       valve_q, valve_d;
    logic       motor_q, motor_d;
    logic       drain_q, drain_d;
    logic       done_q, done_d;

    logic       hold;
    logic       aborting;
    logic       active;
    logic       act;
    logic [2:0] nph;

    function automatic logic [3:0] period_of(input logic [2:0] p);
        case (p)
            3'd1:    period_of = FILL_PERIOD;
            3'd2:    period_of = WASH_PERIOD;
            3'd3:    period_of = RINSE_PERIOD;
            3'd4:    period_of = SPIN_PERIOD;
            default: period_of = 4'd0;
        endcase
    endfunction

    // Lowest phase at or after 'from' with a non-zero period; DONE when none remain.
    function automatic logic [2:0] next_phase(input logic [2:0] from);
        logic [2:0] r;
        r = PH_DONE;
        for (int k = 4; k >= 1; k--) begin
            if (3'(k) >= from && period_of(3'(k)) != 4'd0) r = 3'(k);
        end
        return r;
    endfunction

    always_comb begin
        fsm_d    = fsm_q;
        phase_d  = phase_q;
        held_d   = held_q;
        nph      = PH_IDLE;
        hold     = pause_i || !door_closed_i;
        aborting = abort_i && (fsm_q != S_IDLE);

        case (fsm_q)
            S_IDLE: begin
                if (start_i && door_closed_i) begin
                    nph     = next_phase(3'd1);
                    fsm_d   = (nph == PH_DONE) ? S_DONE : S_LOAD;
                    phase_d = nph;
                    held_d  = 1'b0;
                end
            end
            S_LOAD: begin
                fsm_d  = S_RUN;
                held_d = hold;
            end
            S_RUN: begin
                // done only counts while the timer was actually enabled; it beats a new hold
                if (en_q && tmr.timer_done) begin
                    nph     = next_phase(phase_q + 3'd1);
                    fsm_d   = (nph == PH_DONE) ? S_DONE : S_LOAD;
                    phase_d = nph;
                    held_d  = 1'b0;
                end else begin
                    held_d = hold;
                end
            end
            S_DONE: fsm_d = S_IDLE;
            default: fsm_d = S_IDLE;
        endcase

        if (aborting) begin
            fsm_d   = S_IDLE;
            phase_d = PH_IDLE;
            held_d  = 1'b0;
        end

        active   = (fsm_d == S_LOAD) || (fsm_d == S_RUN);
        act      = active && !held_d;
        clr_d    = (fsm_d == S_LOAD) || aborting;
        en_d     = (fsm_d == S_RUN) && !held_d;
        period_d = active ? period_of(phase_d) : 4'd0;
        state_d  = active ? phase_d : ((fsm_d == S_DONE) ? PH_DONE : PH_IDLE);
        valve_d  = act && (phase_d == 3'd1 || phase_d == 3'd3);
        motor_d  = act && (phase_d >= 3'd2);
        drain_d  = act && (phase_d == 3'd4);
        done_d   = (fsm_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q    <= S_IDLE;
            phase_q  <= PH_IDLE;
            held_q   <= 1'b0;
            clr_q    <= 1'b0;
            en_q     <= 1'b0;
            freq_q   <= CLK_FREQ;
            period_q <= 4'd0;
            state_q  <= PH_IDLE;
            valve_q  <= 1'b0;
            motor_q  <= 1'b0;
            drain_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            phase_q  <= phase_d;
            held_q   <= held_d;
            clr_q    <= clr_d;
            en_q     <= en_d;
            freq_q   <= CLK_FREQ;
            period_q <= period_d;
            state_q  <= state_d;
            valve_q  <= valve_d;
            motor_q  <= motor_d;
            drain_q  <= drain_d;
            done_q   <= done_d;
        end
    end

    assign tmr.timer_clr    = clr_q;
    assign tmr.timer_enable = en_q;
    assign tmr.timer_freq   = freq_q;
    assign tmr.timer_period = period_q;
    assign state_o          = state_q;
    assign water_valve_o    = valve_q;
    assign motor_on_o       = motor_q;
    assign drain_o          = drain_q;
    assign cycle_done_o     = done_q;

endmodule
